// File: rtl/clk_set_ctrl.sv
// -----------------------------------------------------------------------------
// clk_set_ctrl
//
// Purpose:
//   This controller turns three debounced key pulses into the set interface
//   of a time-of-day counter datapath. It keeps a shadow copy of the six BCD
//   digits so that every write it issues is a legal time value. The hour
//   value is limited to 23. It also drives a one-hot blink mask, so the
//   display can flash the digit under edit.
//
// Ports:
//   clk          in   system clock (single domain)
//   rst          in   synchronous, active-high reset
//   key_mode     in   one-cycle pulse: enter / leave set mode
//   key_shift    in   one-cycle pulse: advance edit position (5 wraps to 0)
//   key_inc      in   one-cycle pulse: increment the selected digit
//   work_en      out  1 = datapath counts, 0 = datapath accepts settings
//   set_pos      out  digit index 0=s_l 1=s_h 2=m_l 3=m_h 4=h_l 5=h_h
//   set_data     out  BCD value for set_pos, valid while set_flag=1
//   set_flag     out  one-cycle write strobe
//   digit_blank  out  one-hot blank mask, bit i blanks digit i
//
// Key handshake: keys are single-cycle pulses with no back-pressure. A key is
// acted on only in RUN (key_mode) or SET_IDLE (all keys, priority
// mode > shift > inc). Pulses that arrive in any other state are dropped.
//
// All outputs come from flops. Each next value is computed from the
// next-state decision, so outputs line up with the state they describe.
// -----------------------------------------------------------------------------
module clk_set_ctrl #(
  parameter logic [29:0] TIMEOUT_MAX = 30'd499_999_999,
  parameter logic [23:0] BLINK_MAX   = 24'd12_499_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_shift,
  input  logic       key_inc,
  output logic       work_en,
  output logic [2:0] set_pos,
  output logic [3:0] set_data,
  output logic       set_flag,
  output logic [5:0] digit_blank
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_IDLE = 3'd1,
    ST_WR_DIGIT = 3'd2,
    ST_WR_CLAMP = 3'd3,
    ST_EXIT1    = 3'd4,
    ST_EXIT2    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        work_en_q, work_en_d;
  logic [2:0]  set_pos_q, set_pos_d;
  logic [3:0]  set_data_q, set_data_d;
  logic        set_flag_q, set_flag_d;
  logic [5:0]  digit_blank_q, digit_blank_d;
  logic [3:0]  dig_q [6];
  logic [3:0]  dig_d [6];
  logic [29:0] tmo_q, tmo_d;
  logic [23:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;

  // Selected digit, its wrap limit and its incremented value.
  logic [3:0]  cur_digit;
  logic [3:0]  cur_limit;
  logic [3:0]  inc_val;

  always_comb begin
    cur_digit = dig_q[0];
    cur_limit = 4'd9;
    case (set_pos_q)
      3'd0: begin cur_digit = dig_q[0]; cur_limit = 4'd9; end
      3'd1: begin cur_digit = dig_q[1]; cur_limit = 4'd5; end
      3'd2: begin cur_digit = dig_q[2]; cur_limit = 4'd9; end
      3'd3: begin cur_digit = dig_q[3]; cur_limit = 4'd5; end
      // Hours low digit: 0-9 below 20h, 0-3 from 20h on.
      3'd4: begin
        cur_digit = dig_q[4];
        cur_limit = (dig_q[5] < 4'd2) ? 4'd9 : 4'd3;
      end
      3'd5: begin cur_digit = dig_q[5]; cur_limit = 4'd2; end
      default: begin cur_digit = dig_q[0]; cur_limit = 4'd9; end
    endcase
    // Use >= so that any out-of-range value also wraps to 0.
    inc_val = (cur_digit >= cur_limit) ? 4'd0 : cur_digit + 4'd1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    work_en_d  = work_en_q;
    set_pos_d  = set_pos_q;
    set_data_d = set_data_q;
    set_flag_d = 1'b0;
    tmo_d      = '0;
    for (int i = 0; i < 6; i++) dig_d[i] = dig_q[i];

    case (state_q)
      ST_RUN: begin
        work_en_d = 1'b1;
        if (key_mode) begin
          // The datapath clears its own digits on the work_en falling edge.
          // The shadow copy is cleared here so that both copies agree.
          state_d   = ST_SET_IDLE;
          work_en_d = 1'b0;
          set_pos_d = 3'd0;
          for (int i = 0; i < 6; i++) dig_d[i] = 4'd0;
        end
      end

      ST_SET_IDLE: begin
        work_en_d = 1'b0;
        if (key_mode) begin
          state_d = ST_EXIT1;
        end else if (key_shift) begin
          set_pos_d = (set_pos_q == 3'd5) ? 3'd0 : set_pos_q + 3'd1;
        end else if (key_inc) begin
          for (int i = 0; i < 6; i++) begin
            if (set_pos_q == 3'(i)) dig_d[i] = inc_val;
          end
          set_flag_d = 1'b1;
          set_data_d = inc_val;
          state_d    = ST_WR_DIGIT;
        end else if (tmo_q == TIMEOUT_MAX) begin
          state_d = ST_EXIT1;
        end else begin
          tmo_d = tmo_q + 30'd1;
        end
      end

      ST_WR_DIGIT: begin
        // Raising hours-high to 2 can leave an illegal hour such as 27.
        // In that case, issue a second write that forces hours-low to 3.
        if ((set_pos_q == 3'd5) && (dig_q[5] == 4'd2) && (dig_q[4] > 4'd3)) begin
          dig_d[4]   = 4'd3;
          set_flag_d = 1'b1;
          set_pos_d  = 3'd4;
          set_data_d = 4'd3;
          state_d    = ST_WR_CLAMP;
        end else begin
          state_d = ST_SET_IDLE;
        end
      end

      ST_WR_CLAMP: begin
        set_pos_d = 3'd5;
        state_d   = ST_SET_IDLE;
      end

      // Two extra cycles with work_en low let the datapath finish its
      // one-cycle-delayed load before it resumes counting.
      ST_EXIT1: begin
        work_en_d = 1'b0;
        state_d   = ST_EXIT2;
      end

      ST_EXIT2: begin
        work_en_d = 1'b1;
        state_d   = ST_RUN;
      end

      default: begin
        work_en_d = 1'b1;
        state_d   = ST_RUN;
      end
    endcase
  end

  // Blink timing. Both the counter and the phase stay at zero in RUN and on
  // the entry edge, so the first toggle always comes BLINK_MAX+1 cycles
  // after set mode is entered.
  always_comb begin
    blink_cnt_d   = '0;
    phase_d       = 1'b0;
    digit_blank_d = 6'b000000;
    if ((state_q != ST_RUN) && (state_d != ST_RUN)) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 24'd1;
        phase_d     = phase_q;
      end
    end
    if (phase_d && (state_d != ST_RUN)) digit_blank_d = 6'b000001 << set_pos_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      work_en_q     <= 1'b1;
      set_pos_q     <= 3'd0;
      set_data_q    <= 4'd0;
      set_flag_q    <= 1'b0;
      digit_blank_q <= 6'b000000;
      tmo_q         <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
    end else begin
      state_q       <= state_d;
      work_en_q     <= work_en_d;
      set_pos_q     <= set_pos_d;
      set_data_q    <= set_data_d;
      set_flag_q    <= set_flag_d;
      digit_blank_q <= digit_blank_d;
      tmo_q         <= tmo_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      for (int i = 0; i < 6; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign work_en     = work_en_q;
  assign set_pos     = set_pos_q;
  assign set_data    = set_data_q;
  assign set_flag    = set_flag_q;
  assign digit_blank = digit_blank_q;

endmodule

// File: tb/tb_clk_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_set_ctrl
//
// A directed bench for clk_set_ctrl. It shortens the timeout to 100 cycles
// and the blink period to 8 cycles per phase. Inputs change 1 time unit
// after a rising edge. Outputs are sampled at the same point, so each sample
// shows the effect of the edge that has just passed.
// -----------------------------------------------------------------------------
module tb_clk_set_ctrl;

  localparam logic [29:0] T_MAX = 30'd100;
  localparam logic [23:0] B_MAX = 24'd7;

  logic       clk;
  logic       rst;
  logic       key_mode;
  logic       key_shift;
  logic       key_inc;
  logic       work_en;
  logic [2:0] set_pos;
  logic [3:0] set_data;
  logic       set_flag;
  logic [5:0] digit_blank;

  int checks   = 0;
  int failures = 0;
  logic flag_seen;

  clk_set_ctrl #(
    .TIMEOUT_MAX (T_MAX),
    .BLINK_MAX   (B_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_mode    (key_mode),
    .key_shift   (key_shift),
    .key_inc     (key_inc),
    .work_en     (work_en),
    .set_pos     (set_pos),
    .set_data    (set_data),
    .set_flag    (set_flag),
    .digit_blank (digit_blank)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic s, input logic i);
    key_mode  = m;
    key_shift = s;
    key_inc   = i;
    tick();
    key_mode  = 1'b0;
    key_shift = 1'b0;
    key_inc   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input logic [2:0] pos, input logic [3:0] data);
    chk({tag, "_flag"}, {7'd0, set_flag}, 8'd1);
    chk({tag, "_pos"},  {5'd0, set_pos},  {5'd0, pos});
    chk({tag, "_data"}, {4'd0, set_data}, {4'd0, data});
  endtask

  logic [3:0] exp_d1 [10];
  logic [3:0] exp_d4 [7];

  initial begin
    exp_d1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    exp_d4 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    rst = 1'b1; key_mode = 1'b0; key_shift = 1'b0; key_inc = 1'b0;
    tick();
    tick();

    // Reset values.
    chk("rst_work_en", {7'd0, work_en}, 8'd1);
    chk("rst_set_pos", {5'd0, set_pos}, 8'd0);
    chk("rst_set_data", {4'd0, set_data}, 8'd0);
    chk("rst_set_flag", {7'd0, set_flag}, 8'd0);
    chk("rst_blank", {2'd0, digit_blank}, 8'd0);
    rst = 1'b0;
    tick();

    // Set-mode entry and the first blink toggle.
    pulse(1'b1, 1'b0, 1'b0);
    chk("entry_work_en", {7'd0, work_en}, 8'd0);
    chk("entry_set_pos", {5'd0, set_pos}, 8'd0);
    chk("entry_blank", {2'd0, digit_blank}, 8'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("blink_before", {2'd0, digit_blank}, 8'h00);
    tick();
    chk("blink_on", {2'd0, digit_blank}, 8'h01);

    // Seconds-high increments and wraps at 5.
    pulse(1'b0, 1'b1, 1'b0);
    chk("shift_pos1", {5'd0, set_pos}, 8'd1);
    chk("shift_noflag", {7'd0, set_flag}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      chk_write("inc_d1", 3'd1, exp_d1[i]);
      tick();
      chk("inc_d1_end", {7'd0, set_flag}, 8'd0);
    end

    // Hours-low to 7, then hours-high to 2 forces hours-low to 3.
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0);
    chk("shift_pos4", {5'd0, set_pos}, 8'd4);
    for (int i = 0; i < 7; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      chk_write("inc_d4", 3'd4, exp_d4[i]);
      tick();
    end
    pulse(1'b0, 1'b1, 1'b0);
    chk("shift_pos5", {5'd0, set_pos}, 8'd5);
    pulse(1'b0, 1'b0, 1'b1);
    chk_write("inc_d5_a", 3'd5, 4'd1);
    tick();
    chk("no_clamp_at_1", {7'd0, set_flag}, 8'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk_write("inc_d5_b", 3'd5, 4'd2);
    tick();
    chk_write("clamp", 3'd4, 4'd3);
    tick();
    chk("clamp_done_flag", {7'd0, set_flag}, 8'd0);
    chk("clamp_pos_back", {5'd0, set_pos}, 8'd5);
    pulse(1'b0, 1'b1, 1'b0);
    chk("shift_wrap", {5'd0, set_pos}, 8'd0);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk_write("d4_wrap3", 3'd4, 4'd0);
    tick();

    // Exit timing. A key that arrives during the exit is dropped.
    pulse(1'b1, 1'b0, 1'b0);
    chk("exit1_work_en", {7'd0, work_en}, 8'd0);
    chk("exit1_flag", {7'd0, set_flag}, 8'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("exit2_work_en", {7'd0, work_en}, 8'd0);
    chk("exit2_flag", {7'd0, set_flag}, 8'd0);
    tick();
    chk("exit_run_work_en", {7'd0, work_en}, 8'd1);
    chk("exit_run_flag", {7'd0, set_flag}, 8'd0);
    chk("exit_run_blank", {2'd0, digit_blank}, 8'd0);

    // In RUN, the shift and inc keys are ignored.
    pulse(1'b0, 1'b0, 1'b1);
    chk("run_inc_flag", {7'd0, set_flag}, 8'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("run_shift_pos", {5'd0, set_pos}, 8'd4);
    chk("run_work_en", {7'd0, work_en}, 8'd1);

    // Simultaneous keys.
    pulse(1'b1, 1'b0, 1'b0);
    chk("reentry_pos", {5'd0, set_pos}, 8'd0);
    pulse(1'b1, 1'b0, 1'b1);
    chk("mode_inc_flag", {7'd0, set_flag}, 8'd0);
    chk("mode_inc_work_en", {7'd0, work_en}, 8'd0);
    tick();
    chk("mode_inc_exit2", {7'd0, work_en}, 8'd0);
    tick();
    chk("mode_inc_run", {7'd0, work_en}, 8'd1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    chk("shift_inc_pos", {5'd0, set_pos}, 8'd1);
    chk("shift_inc_flag", {7'd0, set_flag}, 8'd0);
    tick();
    chk("shift_inc_nowrite", {7'd0, set_flag}, 8'd0);

    // A key at cycle 50 restarts the timeout count.
    for (int i = 0; i < 48; i++) tick();
    pulse(1'b0, 1'b1, 1'b0);
    chk("tmo_restart_pos", {5'd0, set_pos}, 8'd2);
    flag_seen = 1'b0;
    for (int i = 0; i < 102; i++) begin
      tick();
      if (set_flag) flag_seen = 1'b1;
    end
    chk("tmo_restart_hold", {7'd0, work_en}, 8'd0);
    tick();
    chk("tmo_restart_exit", {7'd0, work_en}, 8'd1);
    chk("tmo_restart_noflag", {7'd0, flag_seen}, 8'd0);

    // Timeout with no keys returns to RUN 103 cycles after entry.
    pulse(1'b1, 1'b0, 1'b0);
    chk("tmo_entry", {7'd0, work_en}, 8'd0);
    for (int i = 0; i < 102; i++) tick();
    chk("tmo_hold", {7'd0, work_en}, 8'd0);
    tick();
    chk("tmo_exit", {7'd0, work_en}, 8'd1);

    // A reset in the middle of a write restores the reset values.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk_write("pre_rst_write", 3'd0, 4'd1);
    rst = 1'b1;
    tick();
    chk("midrst_work_en", {7'd0, work_en}, 8'd1);
    chk("midrst_flag", {7'd0, set_flag}, 8'd0);
    chk("midrst_pos", {5'd0, set_pos}, 8'd0);
    chk("midrst_data", {4'd0, set_data}, 8'd0);
    chk("midrst_blank", {2'd0, digit_blank}, 8'd0);
    rst = 1'b0;
    tick();

    // Final report.
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
